div_16x8_seq: RTL and testbench



---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 20 ++
 rtl/div_16x8_seq.sv | 117 +++++++++++
 tb/tb_div_16x8_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default sizing for the 16/8 sequential restoring divider.
// DIV_APPROX_EN selects the truncated-iteration build.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DW     = 16;
  localparam int VW     = 8;
  localparam int TRUNC  = 4;
  localparam int ITER_W = $clog2(DW + 1);

`ifdef DIV_APPROX_EN
  localparam int N_ITER = DW - TRUNC;
`else
  localparam int N_ITER = DW;
`endif

endpackage

// File: rtl/div_step.sv
// One restoring-division step: subtract the divisor when it fits and report
// the resulting quotient bit.
module div_step #(
  parameter int VW = div_pkg::VW
) (
  input  logic [VW:0]   p_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   p_out,
  output logic          qbit
);

  logic [VW:0] dvs_ext;

  always_comb begin
    dvs_ext = {1'b0, divisor};
    qbit    = (p_in >= dvs_ext);
    p_out   = qbit ? (p_in - dvs_ext) : p_in;
  end

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_APPROX_EN to run only the top DW-TRUNC iterations (low quotient bits forced 0).
module div_16x8_seq #(
  parameter int DW    = div_pkg::DW,
  parameter int VW    = div_pkg::VW,
  parameter int TRUNC = div_pkg::TRUNC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  import div_pkg::*;

`ifdef DIV_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  // In the truncated build the quotient is scaled back up by the skipped bit count.
  localparam int SHIFT = APPROX ? TRUNC : 0;
  localparam int ITERS = DW - SHIFT;
  localparam int CNT_W = $clog2(DW + 1);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    dvd_sr;
  logic [VW-1:0]    dvs;
  logic [VW-1:0]    p;
  logic [DW-2:0]    quo_sr;

  logic [VW:0]      step_in;
  logic [VW:0]      step_out;
  logic             qbit;
  logic [DW-1:0]    quo_next;
  logic             step_unused;

  assign in_ready    = (state == IDLE);
  assign step_in     = {p, dvd_sr[DW-1]};
  assign quo_next    = {quo_sr, qbit};
  // The step result is always below the divisor, so its top bit is never set.
  assign step_unused = step_out[VW];

  div_step #(.VW(VW)) u_step (
    .p_in    (step_in),
    .divisor (dvs),
    .p_out   (step_out),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_sr    <= '0;
      dvs       <= '0;
      p         <= '0;
      quo_sr    <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            p      <= '0;
            quo_sr <= '0;
            dvd_sr <= dividend;
            dvs    <= divisor;
            // Divide-by-zero skips the iterations and reports a saturated quotient.
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[VW-1:0];
              div_zero  <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          p      <= step_out[VW-1:0];
          dvd_sr <= {dvd_sr[DW-2:0], 1'b0};
          quo_sr <= quo_next[DW-2:0];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= quo_next << SHIFT;
            remainder <= step_out[VW-1:0];
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_16x8_seq.sv
// Self-checking bench for div_16x8_seq: directed vector table, handshake corner
// cases, and a randomized run scored against a behavioural model.
module tb_div_16x8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

`ifdef DIV_APPROX_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 16;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
  } vec_t;

  res_t sb[$];
  vec_t vecs[8];

  div_16x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Independent arithmetic reference, truncating the dividend in the approximate build.
  function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
    res_t res;
    logic [15:0] num;
    if (b == 8'd0) begin
      res.q = 16'hFFFF;
      res.r = a[7:0];
      res.z = 1'b1;
    end else begin
`ifdef DIV_APPROX_EN
      num   = a >> 4;
      res.q = (num / {8'd0, b}) << 4;
`else
      num   = a;
      res.q = num / {8'd0, b};
`endif
      res.r = 8'(num % {8'd0, b});
      res.z = 1'b0;
    end
    return res;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    res_t exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got a result, expected none pending", name);
    end else begin
      exp = sb.pop_front();
      checkVal({name, "_quotient"}, 32'(quotient), 32'(exp.q));
      checkVal({name, "_remainder"}, 32'(remainder), 32'(exp.r));
      checkVal({name, "_div_zero"}, 32'(div_zero), 32'(exp.z));
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, input res_t exp);
    int n = 0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkVal("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic waitResult(input int lat, input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal({name, "_latency"}, 32'(n), 32'(lat));
  endtask

  task automatic acceptResult(input string name);
    out_ready = 1'b1;
    checkOutput(name);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checkVal({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    checkVal({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t        exp;
    logic [15:0] ra;
    logic [7:0]  rb;
    bit          acc;
    int          sent;
    int          got;
    int          nr;

`ifdef DIV_APPROX_EN
    vecs[0] = '{16'd1000,  8'd7,   16'd128,   8'd6,   1'b0, 12};
    vecs[1] = '{16'hFFFF,  8'd1,   16'hFFF0,  8'd0,   1'b0, 12};
    vecs[2] = '{16'h00FF,  8'hFF,  16'd0,     8'h0F,  1'b0, 12};
    vecs[3] = '{16'd5,     8'd9,   16'd0,     8'd0,   1'b0, 12};
    vecs[4] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1, 0};
    vecs[5] = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 12};
    vecs[6] = '{16'hFFFF,  8'hFF,  16'd256,   8'd15,  1'b0, 12};
    vecs[7] = '{16'd200,   8'd3,   16'd64,    8'd0,   1'b0, 12};
`else
    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
    vecs[1] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0, 16};
    vecs[2] = '{16'h00FF,  8'hFF,  16'd1,     8'd0,   1'b0, 16};
    vecs[3] = '{16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 16};
    vecs[4] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1, 0};
    vecs[5] = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0, 16};
    vecs[6] = '{16'hFFFF,  8'hFF,  16'd257,   8'd0,   1'b0, 16};
    vecs[7] = '{16'd200,   8'd3,   16'd66,    8'd2,   1'b0, 16};
`endif

    repeat (3) @(negedge clk);
    checkVal("reset_in_ready", 32'(in_ready), 32'd1);
    checkVal("reset_out_valid", 32'(out_valid), 32'd0);
    checkVal("reset_quotient", 32'(quotient), 32'd0);
    checkVal("reset_remainder", 32'(remainder), 32'd0);
    checkVal("reset_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, res_t'{vecs[i].q, vecs[i].r, vecs[i].z});
      waitResult(vecs[i].lat, $sformatf("vec%0d", i));
      acceptResult($sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while the consumer stalls; new requests are ignored.
    exp = model(16'd1000, 8'd7);
    applyStimulus(16'd1000, 8'd7, exp);
    waitResult(LAT, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 16'(i * 313 + 17);
      divisor  = 8'(i + 1);
      checkVal("bp_in_ready", 32'(in_ready), 32'd0);
      checkVal("bp_out_valid", 32'(out_valid), 32'd1);
      checkVal("bp_quotient_hold", 32'(quotient), 32'(exp.q));
      checkVal("bp_remainder_hold", 32'(remainder), 32'(exp.r));
      @(negedge clk);
    end
    in_valid = 1'b0;
    acceptResult("bp");
    checkVal("bp_quotient_kept", 32'(quotient), 32'(exp.q));

    // Asynchronous reset in the middle of an operation discards it.
    applyStimulus(16'd1000, 8'd7, model(16'd1000, 8'd7));
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("abort_in_ready", 32'(in_ready), 32'd1);
    checkVal("abort_out_valid", 32'(out_valid), 32'd0);
    checkVal("abort_quotient", 32'(quotient), 32'd0);
    checkVal("abort_remainder", 32'(remainder), 32'd0);
    checkVal("abort_div_zero", 32'(div_zero), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'd200, 8'd3, res_t'{vecs[7].q, vecs[7].r, vecs[7].z});
    waitResult(LAT, "post_reset");
    acceptResult("post_reset");

    // Random traffic with gaps on both handshakes.
    nr   = 1500;
    sent = 0;
    got  = 0;
    acc  = 1'b0;
    ra   = '0;
    rb   = '0;
    for (int cyc = 0; cyc < 60000 && got < nr; cyc++) begin
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0;
        acc = 1'b0;
      end
      if (!in_valid && sent < nr && $urandom_range(3) != 0) begin
        ra = 16'($urandom);
        case ($urandom_range(7))
          0:       rb = 8'd0;
          1:       rb = 8'd1;
          2:       rb = 8'hFF;
          default: rb = 8'($urandom_range(255, 1));
        endcase
        dividend = ra;
        divisor  = rb;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      if (out_valid && out_ready) begin
        checkOutput("rand");
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(ra, rb));
        sent++;
        acc = 1'b1;
      end
    end
    checkVal("rand_results_seen", 32'(got), 32'(nr));
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
